// File: rtl/rom_rr_arbiter.sv
// Two-requester arbiter in front of a combinational-read ROM: registered address and read data.
// Define ARB_FIXED_PRIO_EN to make requester 0 always win contention instead of round-robin.
module rom_rr_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    typedef enum logic {IDLE, READ} state_t;

    state_t              state_q;
    logic                owner_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic                pick1;
    logic                idle_ok;

`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    // last_gnt_q resets to 1 so requester 0 wins the first contention.
    logic last_gnt_q;
    assign pick1 = req1 & (~req0 | ~last_gnt_q);
`endif

    // Grants are combinational; reset suppresses them in the same cycle.
    assign idle_ok = (state_q == IDLE) & ~rst;
    assign gnt0    = idle_ok & req0 & ~pick1;
    assign gnt1    = idle_ok & pick1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rom_addr_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        rom_addr_q <= gnt1 ? addr1 : addr0;
                        owner_q    <= gnt1;
                        state_q    <= READ;
                    end
                end
                READ: begin
                    if (owner_q) begin
                        rdata1_q  <= rom_data;
                        rvalid1_q <= 1'b1;
                    end else begin
                        rdata0_q  <= rom_data;
                        rvalid0_q <= 1'b1;
                    end
`ifndef ARB_FIXED_PRIO_EN
                    last_gnt_q <= owner_q;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr = rom_addr_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = (state_q == READ);

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Self-checking bench for rom_rr_arbiter (default round-robin build): cycle table plus read-data scoreboard.
module tb_rom_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [3:0] addr0, addr1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [7:0] rdata0, rdata1;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       req0;
        logic       req1;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [4:0] exp;   // {gnt0, gnt1, busy, rvalid0, rvalid1}
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] data;
    } rd_t;

    vec_t       tbl[$];
    rd_t        sb[$];
    logic [7:0] exp_rd0, exp_rd1;

    function automatic logic [7:0] rom_img(input logic [3:0] a);
        case (a)
            4'd0:    return 8'hAA;
            4'd3:    return 8'hDD;
            4'd5:    return 8'hFF;
            4'd9:    return 8'h44;
            4'd15:   return 8'h00;
            default: return {4'hC, a};
        endcase
    endfunction

    assign rom_data = rom_img(rom_addr);

    rom_rr_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic q0, input logic q1,
                                input logic [3:0] a0, input logic [3:0] a1, input logic [4:0] e);
        vec_t v;
        v.rst = r; v.req0 = q0; v.req1 = q1; v.a0 = a0; v.a1 = a1; v.exp = e;
        return v;
    endfunction

    // Drive one cycle at the falling edge, check before the next rising edge.
    task automatic run_row(input vec_t v, input int idx);
        logic [4:0] act;
        rd_t        e;
        rst = v.rst; req0 = v.req0; req1 = v.req1; addr0 = v.a0; addr1 = v.a1;
        #2;
        act = {gnt0, gnt1, busy, rvalid0, rvalid1};
        checks++;
        if (act !== v.exp) begin
            failures++;
            $display("FAIL ctl row%0d actual=%b required=%b (gnt0 gnt1 busy rv0 rv1)", idx, act, v.exp);
        end
        if (rvalid0 || rvalid1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rvalid row%0d rv0=%b rv1=%b", idx, rvalid0, rvalid1);
            end else begin
                e = sb.pop_front();
                if (e.id) exp_rd1 = e.data; else exp_rd0 = e.data;
                if ({rvalid1, rvalid1 ? rdata1 : rdata0} !== {e.id, e.data}) begin
                    failures++;
                    $display("FAIL rdata row%0d actual id=%0d data=%h required id=%0d data=%h",
                             idx, rvalid1, rvalid1 ? rdata1 : rdata0, e.id, e.data);
                end
            end
        end
        checks++;
        if ({rdata0, rdata1} !== {exp_rd0, exp_rd1}) begin
            failures++;
            $display("FAIL rdata_hold row%0d actual=%h/%h required=%h/%h",
                     idx, rdata0, rdata1, exp_rd0, exp_rd1);
        end
        if (v.exp[4]) sb.push_back('{1'b0, rom_img(v.a0)});
        if (v.exp[3]) sb.push_back('{1'b1, rom_img(v.a1)});
        if (v.rst) begin
            sb.delete();
            exp_rd0 = '0;
            exp_rd1 = '0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        exp_rd0 = '0; exp_rd1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset beats a simultaneous request
        tbl.push_back(mk(1, 1, 0, 4'd3, 4'd0, 5'b00000));
        // single read at addr 3
        tbl.push_back(mk(0, 1, 0, 4'd3, 4'd0, 5'b10000));
        tbl.push_back(mk(0, 0, 0, 4'd3, 4'd0, 5'b00100));
        tbl.push_back(mk(0, 0, 0, 4'd3, 4'd0, 5'b00010));
        tbl.push_back(mk(0, 0, 0, 4'd3, 4'd0, 5'b00000));
        // continuous contention, last winner was 0 so 1 goes first
        tbl.push_back(mk(0, 1, 1, 4'd5, 4'd9, 5'b01000));
        tbl.push_back(mk(0, 1, 1, 4'd5, 4'd9, 5'b00100));
        tbl.push_back(mk(0, 1, 1, 4'd5, 4'd9, 5'b10001));
        tbl.push_back(mk(0, 1, 1, 4'd5, 4'd9, 5'b00100));
        tbl.push_back(mk(0, 1, 1, 4'd5, 4'd9, 5'b01010));
        tbl.push_back(mk(0, 1, 1, 4'd5, 4'd9, 5'b00100));
        tbl.push_back(mk(0, 0, 0, 4'd5, 4'd9, 5'b00001));
        tbl.push_back(mk(0, 0, 0, 4'd5, 4'd9, 5'b00000));
        // addr 15, address changed after grant
        tbl.push_back(mk(0, 0, 1, 4'd5, 4'd15, 5'b01000));
        tbl.push_back(mk(0, 0, 0, 4'd5, 4'd0,  5'b00100));
        tbl.push_back(mk(0, 0, 0, 4'd5, 4'd0,  5'b00001));
        // back-to-back reads by requester 0
        tbl.push_back(mk(0, 1, 0, 4'd0, 4'd0, 5'b10000));
        tbl.push_back(mk(0, 1, 0, 4'd3, 4'd0, 5'b00100));
        tbl.push_back(mk(0, 1, 0, 4'd3, 4'd0, 5'b10010));
        tbl.push_back(mk(0, 0, 0, 4'd3, 4'd0, 5'b00100));
        tbl.push_back(mk(0, 0, 0, 4'd3, 4'd0, 5'b00010));
        // reset during READ aborts, then requester 0 wins contention
        tbl.push_back(mk(0, 0, 1, 4'd0, 4'd5, 5'b01000));
        tbl.push_back(mk(1, 0, 0, 4'd0, 4'd5, 5'b00100));
        tbl.push_back(mk(0, 1, 1, 4'd9, 4'd3, 5'b10000));
        tbl.push_back(mk(0, 0, 0, 4'd9, 4'd3, 5'b00100));
        tbl.push_back(mk(0, 0, 0, 4'd9, 4'd3, 5'b00010));
        // req0 pulsed only while busy
        tbl.push_back(mk(0, 0, 1, 4'd9, 4'd3, 5'b01000));
        tbl.push_back(mk(0, 1, 0, 4'd5, 4'd3, 5'b00100));
        tbl.push_back(mk(0, 0, 0, 4'd5, 4'd3, 5'b00001));
        tbl.push_back(mk(0, 0, 0, 4'd5, 4'd3, 5'b00000));

        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

        // Long contention run: last winner was 1, so strict 0,1,0,1 alternation.
        for (int i = 0; i < 12; i++) begin
            logic g0, g1, bz, v0, v1;
            g0 = (i % 4 == 0);
            g1 = (i % 4 == 2);
            bz = (i % 2 == 1);
            v0 = (i > 0) && (i % 4 == 2);
            v1 = (i > 0) && (i % 4 == 0);
            run_row(mk(0, 1, 1, 4'd9, 4'd0, {g0, g1, bz, v0, v1}), 100 + i);
        end
        run_row(mk(0, 0, 0, 4'd9, 4'd0, 5'b00001), 112);
        run_row(mk(0, 0, 0, 4'd9, 4'd0, 5'b00000), 113);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
